// File: rtl/wb_pkg.sv
// Shared definitions for the N-lane writeback stage.
// Contents:
//   ld_size_e   load size encodings as they arrive from the MEM stage
//   DEF_*       default widths used by the stage and its lane slice
package wb_pkg;

   // Load size codes. Code 2'b11 is treated as a full word as well.
   typedef enum logic [1:0] {
      LD_WORD     = 2'b00,
      LD_HALF     = 2'b01,
      LD_BYTE     = 2'b10,
      LD_WORD_ALT = 2'b11
   } ld_size_e;

   localparam int DEF_LANES  = 2;
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_REG_AW = 5;
   localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/wb_lane_align.sv
// One writeback lane: chooses the ALU/address result or the load data, and for
// sub-word loads extracts the addressed half/byte and sign- or zero-extends it.
// Purely combinational.
// Ports:
//   sel_wb     1 = pass alu_data through, 0 = use (aligned) mem_data
//   alu_data   ALU/address result
//   mem_data   raw data-memory word
//   ld_size    load size code (see wb_pkg)
//   ld_signed  1 = sign-extend sub-word loads
//   byte_off   low two address bits of the load
//   data       resulting writeback value
module wb_lane_align
   import wb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)
(
   input  logic             sel_wb,
   input  logic [WIDTH-1:0] alu_data,
   input  logic [WIDTH-1:0] mem_data,
   input  logic [1:0]       ld_size,
   input  logic             ld_signed,
   input  logic [1:0]       byte_off,
   output logic [WIDTH-1:0] data
);

   logic [WIDTH-1:0] load_val;

   generate
      if (WIDTH == 32) begin : g_align
         logic [15:0] half_field;
         logic [7:0]  byte_field;

         // Half loads only look at byte_off[1]; an odd offset inside a half
         // is not a legal access, so bit 0 is simply ignored.
         always_comb begin
            half_field = byte_off[1] ? mem_data[31:16] : mem_data[15:0];
            byte_field = mem_data[7:0];
            case (byte_off)
               2'd0:    byte_field = mem_data[7:0];
               2'd1:    byte_field = mem_data[15:8];
               2'd2:    byte_field = mem_data[23:16];
               default: byte_field = mem_data[31:24];
            endcase
            case (ld_size)
               LD_HALF: load_val = {{16{ld_signed & half_field[15]}}, half_field};
               LD_BYTE: load_val = {{24{ld_signed & byte_field[7]}}, byte_field};
               default: load_val = mem_data;
            endcase
         end
      end else begin : g_word_only
         // Non-32-bit datapaths only support whole-word loads.
         assign load_val = mem_data;
      end
   endgenerate

   assign data = sel_wb ? alu_data : load_val;

endmodule

// File: rtl/wb_stage_n.sv
// Registered N-lane writeback stage. Aligns each lane's result, resolves
// same-cycle register-file write conflicts (youngest lane wins), and registers
// the RF write ports, which double as the forwarding bus. Also counts retired
// instructions.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   stall                 hold every register
//   flush                 drop the incoming bundle (rf_we cleared)
//   in_valid, sel_wb, alu_data, mem_data, ld_size, ld_signed, byte_off,
//   wr_en, wr_addr        per-lane MEM-stage bundle, lane i in slice i
//   rf_we, rf_waddr,
//   rf_wdata              registered RF write ports / forwarding bus
//   retired               valid lanes retired since reset (wraps)
module wb_stage_n
   import wb_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int WIDTH  = DEF_WIDTH,
   parameter int REG_AW = DEF_REG_AW,
   parameter int CNT_W  = DEF_CNT_W
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    flush,
   input  logic [LANES-1:0]        in_valid,
   input  logic [LANES-1:0]        sel_wb,
   input  logic [LANES*WIDTH-1:0]  alu_data,
   input  logic [LANES*WIDTH-1:0]  mem_data,
   input  logic [LANES*2-1:0]      ld_size,
   input  logic [LANES-1:0]        ld_signed,
   input  logic [LANES*2-1:0]      byte_off,
   input  logic [LANES-1:0]        wr_en,
   input  logic [LANES*REG_AW-1:0] wr_addr,
   output logic [LANES-1:0]        rf_we,
   output logic [LANES*REG_AW-1:0] rf_waddr,
   output logic [LANES*WIDTH-1:0]  rf_wdata,
   output logic [CNT_W-1:0]        retired
);

   logic [LANES*WIDTH-1:0] wdata_next;
   logic [LANES-1:0]       we_raw;
   logic [LANES-1:0]       we_next;
   logic [CNT_W-1:0]       valid_cnt;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         wb_lane_align #(.WIDTH(WIDTH)) u_align (
            .sel_wb    (sel_wb[i]),
            .alu_data  (alu_data[i*WIDTH +: WIDTH]),
            .mem_data  (mem_data[i*WIDTH +: WIDTH]),
            .ld_size   (ld_size[i*2 +: 2]),
            .ld_signed (ld_signed[i]),
            .byte_off  (byte_off[i*2 +: 2]),
            .data      (wdata_next[i*WIDTH +: WIDTH])
         );
      end
   endgenerate

   // Writes to r0 are dropped. When two lanes target the same register the
   // older lane is suppressed so the younger (program-order later) value lands.
   always_comb begin
      we_raw = '0;
      for (int i = 0; i < LANES; i++) begin
         we_raw[i] = in_valid[i] & wr_en[i] & (wr_addr[i*REG_AW +: REG_AW] != '0);
      end
      we_next = we_raw;
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (we_raw[i] && we_raw[j] &&
                (wr_addr[i*REG_AW +: REG_AW] == wr_addr[j*REG_AW +: REG_AW])) begin
               we_next[i] = 1'b0;
            end
         end
      end
   end

   // Every valid lane retires, whether or not it writes a register.
   always_comb begin
      valid_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         valid_cnt = valid_cnt + CNT_W'(in_valid[i]);
      end
   end

   // Pipeline register. Flush only has to kill the write enables; address and
   // data are left as they were since nothing consumes them without rf_we.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we    <= '0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         retired  <= '0;
      end else if (flush) begin
         rf_we    <= '0;
      end else if (!stall) begin
         rf_we    <= we_next;
         rf_waddr <= wr_addr;
         rf_wdata <= wdata_next;
         retired  <= retired + valid_cnt;
      end
   end

endmodule

// File: tb/tb_wb_stage_n.sv
// Self-checking bench for wb_stage_n (2 lanes, 32-bit, 4-bit retire counter
// so that wrap-around is reachable quickly).
module tb_wb_stage_n;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  in_valid = '0;
   logic [1:0]  sel_wb = '0;
   logic [63:0] alu_data = '0;
   logic [63:0] mem_data = '0;
   logic [3:0]  ld_size = '0;
   logic [1:0]  ld_signed = '0;
   logic [3:0]  byte_off = '0;
   logic [1:0]  wr_en = '0;
   logic [9:0]  wr_addr = '0;
   logic [1:0]  rf_we;
   logic [9:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic [3:0]  retired;

   int total = 0;
   int bad = 0;

   wb_stage_n #(.LANES(2), .WIDTH(32), .REG_AW(5), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .flush     (flush),
      .in_valid  (in_valid),
      .sel_wb    (sel_wb),
      .alu_data  (alu_data),
      .mem_data  (mem_data),
      .ld_size   (ld_size),
      .ld_signed (ld_signed),
      .byte_off  (byte_off),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   // Reference value of one lane, computed with shifts and masks.
   function automatic logic [31:0] laneValue(input logic sel, input logic [31:0] alu,
                                             input logic [31:0] mem, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] off);
      logic [31:0] f;
      if (sel) return alu;
      if (size == 2'd1) begin
         f = (mem >> (int'(off[1]) * 16)) & 32'h0000_FFFF;
         if (sgn && f[15]) f = f | 32'hFFFF_0000;
         return f;
      end
      if (size == 2'd2) begin
         f = (mem >> (int'(off) * 8)) & 32'h0000_00FF;
         if (sgn && f[7]) f = f | 32'hFFFF_FF00;
         return f;
      end
      return mem;
   endfunction

   logic [1:0]  m_we = '0;
   logic [4:0]  m_addr [2];
   logic [31:0] m_data [2];
   logic [3:0]  m_ret = '0;
   int          cyc = 0;

   // Behavioural model plus per-cycle comparison against the DUT.
   always @(posedge clk) begin
      logic [31:0] claimed;
      logic [4:0]  a;
      cyc = cyc + 1;
      if (reset) begin
         m_we = '0;
         m_ret = '0;
         for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
         end
      end else if (flush) begin
         m_we = '0;
      end else if (!stall) begin
         claimed = '0;
         for (int i = 1; i >= 0; i--) begin
            a = wr_addr[i*5 +: 5];
            m_addr[i] = a;
            m_data[i] = laneValue(sel_wb[i], alu_data[i*32 +: 32], mem_data[i*32 +: 32],
                                  ld_size[i*2 +: 2], ld_signed[i], byte_off[i*2 +: 2]);
            if (in_valid[i] && wr_en[i] && a != 5'd0 && !claimed[a]) begin
               m_we[i] = 1'b1;
               claimed[a] = 1'b1;
            end else begin
               m_we[i] = 1'b0;
            end
         end
         m_ret = m_ret + 4'(in_valid[0]) + 4'(in_valid[1]);
      end
      #3;
      total = total + 1;
      if (rf_we !== m_we) begin
         bad = bad + 1;
         $display("[TB] FAIL model_we cycle %0d got %b want %b", cyc, rf_we, m_we);
      end
      total = total + 1;
      if (retired !== m_ret) begin
         bad = bad + 1;
         $display("[TB] FAIL model_retired cycle %0d got %h want %h", cyc, retired, m_ret);
      end
      for (int i = 0; i < 2; i++) begin
         if (m_we[i]) begin
            total = total + 1;
            if (rf_waddr[i*5 +: 5] !== m_addr[i] || rf_wdata[i*32 +: 32] !== m_data[i]) begin
               bad = bad + 1;
               $display("[TB] FAIL model_lane%0d cycle %0d got %0d/%h want %0d/%h", i, cyc,
                        rf_waddr[i*5 +: 5], rf_wdata[i*32 +: 32], m_addr[i], m_data[i]);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] v, input logic [1:0] s,
                                input logic [63:0] alu, input logic [63:0] mem,
                                input logic [3:0] size, input logic [1:0] sgn,
                                input logic [3:0] off, input logic [1:0] wen,
                                input logic [9:0] addr, input logic st, input logic fl);
      in_valid = v;
      sel_wb = s;
      alu_data = alu;
      mem_data = mem;
      ld_size = size;
      ld_signed = sgn;
      byte_off = off;
      wr_en = wen;
      wr_addr = addr;
      stall = st;
      flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("[TB] FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   initial begin
      // Reset with random inputs for two cycles.
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         applyStimulus(2'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                       4'($urandom), 2'($urandom), 4'($urandom), 2'($urandom),
                       10'($urandom), 1'($urandom), 1'($urandom));
         checkOutput("reset_we", 64'(rf_we), 64'h0);
         checkOutput("reset_wdata", rf_wdata, 64'h0);
         checkOutput("reset_retired", 64'(retired), 64'h0);
      end
      reset = 1'b0;

      // Signed byte at offset 3, lane 0.
      applyStimulus(2'b01, 2'b00, 64'h0, {32'h0, 32'h80FF1234}, 4'b0010, 2'b01, 4'b0011,
                    2'b01, {5'd0, 5'd3}, 1'b0, 1'b0);
      checkOutput("byte_signed", 64'(rf_wdata[31:0]), 64'hFFFFFF80);
      checkOutput("byte_signed_we", 64'(rf_we), 64'h1);
      checkOutput("retired_1", 64'(retired), 64'h1);

      // Unsigned half on lane 1, offset 2 then 3.
      applyStimulus(2'b10, 2'b00, 64'h0, {32'h9ABC5678, 32'h0}, 4'b0100, 2'b00, 4'b1000,
                    2'b10, {5'd9, 5'd0}, 1'b0, 1'b0);
      checkOutput("half_off2", 64'(rf_wdata[63:32]), 64'h00009ABC);
      applyStimulus(2'b10, 2'b00, 64'h0, {32'h9ABC5678, 32'h0}, 4'b0100, 2'b00, 4'b1100,
                    2'b10, {5'd9, 5'd0}, 1'b0, 1'b0);
      checkOutput("half_off3", 64'(rf_wdata[63:32]), 64'h00009ABC);
      checkOutput("retired_3", 64'(retired), 64'h3);

      // Signed half on lane 0, unsigned byte offset 1 on lane 1.
      applyStimulus(2'b11, 2'b00, 64'h0, {32'h0000AB00, 32'h12348001}, 4'b1001, 2'b01, 4'b0100,
                    2'b11, {5'd4, 5'd5}, 1'b0, 1'b0);
      checkOutput("half_signed", 64'(rf_wdata[31:0]), 64'hFFFF8001);
      checkOutput("byte_unsigned", 64'(rf_wdata[63:32]), 64'h000000AB);

      // Word load (code 11) ignores offset; lane 1 takes ALU result.
      applyStimulus(2'b11, 2'b10, {32'hCAFEF00D, 32'h0}, {32'h11111111, 32'hDEADBEEF}, 4'b0011,
                    2'b00, 4'b0010, 2'b11, {5'd6, 5'd8}, 1'b0, 1'b0);
      checkOutput("word_load", rf_wdata, 64'hCAFEF00D_DEADBEEF);
      checkOutput("retired_7", 64'(retired), 64'h7);

      // Same-destination conflict: lane 1 wins.
      applyStimulus(2'b11, 2'b11, {32'h2222, 32'h1111}, 64'h0, 4'b0, 2'b0, 4'b0,
                    2'b11, {5'd7, 5'd7}, 1'b0, 1'b0);
      checkOutput("conflict_we", 64'(rf_we), 64'h2);
      checkOutput("conflict_addr", 64'(rf_waddr[9:5]), 64'd7);

      // Lane 1 targets r0: no write there.
      applyStimulus(2'b11, 2'b11, {32'h2222, 32'h1111}, 64'h0, 4'b0, 2'b0, 4'b0,
                    2'b11, {5'd0, 5'd7}, 1'b0, 1'b0);
      checkOutput("r0_we", 64'(rf_we), 64'h1);
      checkOutput("retired_11", 64'(retired), 64'hB);

      // Stall three cycles: everything frozen.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(2'b11, 2'b11, {32'h7777, 32'h6666}, 64'h0, 4'b0, 2'b0, 4'b0,
                       2'b11, {5'd12, 5'd13}, 1'b1, 1'b0);
         checkOutput("stall_we", 64'(rf_we), 64'h1);
         checkOutput("stall_data", 64'(rf_wdata[31:0]), 64'h1111);
         checkOutput("stall_retired", 64'(retired), 64'hB);
      end

      // Flush overrides stall.
      applyStimulus(2'b11, 2'b11, {32'h7777, 32'h6666}, 64'h0, 4'b0, 2'b0, 4'b0,
                    2'b11, {5'd12, 5'd13}, 1'b1, 1'b1);
      checkOutput("flush_we", 64'(rf_we), 64'h0);
      checkOutput("flush_retired", 64'(retired), 64'hB);

      // Valid lane without wr_en still retires.
      applyStimulus(2'b01, 2'b01, 64'h5, 64'h0, 4'b0, 2'b0, 4'b0,
                    2'b00, {5'd0, 5'd3}, 1'b0, 1'b0);
      checkOutput("nowrite_we", 64'(rf_we), 64'h0);
      checkOutput("nowrite_retired", 64'(retired), 64'hC);

      applyStimulus(2'b11, 2'b11, {32'h3, 32'h2}, 64'h0, 4'b0, 2'b0, 4'b0,
                    2'b11, {5'd3, 5'd2}, 1'b0, 1'b0);
      checkOutput("retired_14", 64'(retired), 64'hE);

      // Reset during stall wins.
      reset = 1'b1;
      applyStimulus(2'b11, 2'b11, {32'h3, 32'h2}, 64'h0, 4'b0, 2'b0, 4'b0,
                    2'b11, {5'd3, 5'd2}, 1'b1, 1'b1);
      checkOutput("reset_stall_we", 64'(rf_we), 64'h0);
      checkOutput("reset_stall_data", rf_wdata, 64'h0);
      checkOutput("reset_stall_retired", 64'(retired), 64'h0);
      reset = 1'b0;

      // Counter wrap: two lanes per cycle for eight cycles.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(2'b11, 2'b11, {32'(k + 100), 32'(k)}, 64'h0, 4'b0, 2'b0, 4'b0,
                       2'b11, {5'(k + 17), 5'(k + 1)}, 1'b0, 1'b0);
         if (k == 6) checkOutput("wrap_E", 64'(retired), 64'hE);
         if (k == 7) checkOutput("wrap_0", 64'(retired), 64'h0);
      end

      applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 4'b0, 2'b0, 4'b0, 2'b00, 10'h0, 1'b0, 1'b0);
      #5;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
